// File: rtl/pwm_capture.sv
// PWM input measurement: period, high time and per-mille duty of a synchronised PWM pin,
// with a dead-line (no rising edge) detector.
module pwm_capture #(
    parameter int unsigned sys_clk     = 24_000_000,
    parameter int unsigned pwm_fre     = 5000,
    parameter int unsigned CNT_W       = 26,
    parameter int unsigned TIMEOUT_CYC = 4 * sys_clk / pwm_fre
) (
    input  logic             clk_24M,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [10:0]      perctg_out,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             valid,
    output logic             stuck
);

    localparam int unsigned NUM_W  = CNT_W + 10;
    localparam int unsigned STEP_W = $clog2(NUM_W + 1);

    localparam logic [CNT_W-1:0]  CntMax     = '1;
    localparam logic [CNT_W-1:0]  TimeoutVal = CNT_W'(TIMEOUT_CYC);
    localparam logic [NUM_W-1:0]  Scale      = NUM_W'(1000);
    localparam logic [10:0]       PerMille   = 11'd1000;
    localparam logic [STEP_W-1:0] Steps      = STEP_W'(NUM_W);

    typedef enum logic [1:0] {StIdle, StArmed, StSeenFall, StStuck} state_e;

    state_e state_q, state_d;

    logic [1:0]        sync_q;
    logic              pwm_d_q;
    logic              rise, fall;
    logic [CNT_W-1:0]  period_cnt_q, high_cnt_q, high_lat_q;
    logic              capture, timeout;

    logic              div_busy_q, div_done_q;
    logic [STEP_W-1:0] div_cnt_q;
    logic [NUM_W-1:0]  div_num_q, div_quo_q;
    logic [CNT_W-1:0]  div_rem_q, div_den_q, div_high_q;
    logic [CNT_W:0]    div_trial;
    logic [CNT_W-1:0]  div_diff, div_rem_next;
    logic              div_qbit;

    // sync_q[1] is the synchronised input; pwm_d_q is its previous value for edge detection
    assign rise = sync_q[1] & ~pwm_d_q;
    assign fall = ~sync_q[1] & pwm_d_q;

    always_ff @(posedge clk_24M or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            pwm_d_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], pwm_in};
            pwm_d_q <= sync_q[1];
        end
    end

    always_ff @(posedge clk_24M or posedge rst) begin
        if (rst) begin
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            high_lat_q   <= '0;
        end else begin
            if (rise) begin
                period_cnt_q <= CNT_W'(1);
            end else if (period_cnt_q != CntMax) begin
                period_cnt_q <= period_cnt_q + CNT_W'(1);
            end
            if (rise) begin
                high_cnt_q <= CNT_W'(1);
            end else if (sync_q[1] && high_cnt_q != CntMax) begin
                high_cnt_q <= high_cnt_q + CNT_W'(1);
            end
            if (fall) begin
                high_lat_q <= high_cnt_q;
            end
        end
    end

    always_ff @(posedge clk_24M or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        timeout = 1'b0;
        case (state_q)
            StIdle:     if (rise) state_d = StArmed;
            StArmed:    if (fall) state_d = StSeenFall;
            StSeenFall: begin
                if (rise) begin
                    capture = 1'b1;
                    state_d = StArmed;
                end
            end
            StStuck:    if (rise) state_d = StArmed;
            default:    state_d = StIdle;
        endcase
        // A rise in the same cycle restarts the period, so it overrides the timeout
        if ((state_q == StArmed || state_q == StSeenFall) && !rise &&
            period_cnt_q == TimeoutVal) begin
            timeout = 1'b1;
            state_d = StStuck;
        end
    end

    // Restoring division: the low remainder bits suffice because the remainder stays below den
    assign div_trial    = {div_rem_q, div_num_q[NUM_W-1]};
    assign div_qbit     = div_trial >= {1'b0, div_den_q};
    assign div_diff     = div_trial[CNT_W-1:0] - div_den_q;
    assign div_rem_next = div_qbit ? div_diff : div_trial[CNT_W-1:0];

    always_ff @(posedge clk_24M or posedge rst) begin
        if (rst) begin
            div_busy_q <= 1'b0;
            div_done_q <= 1'b0;
            div_cnt_q  <= '0;
            div_num_q  <= '0;
            div_quo_q  <= '0;
            div_rem_q  <= '0;
            div_den_q  <= '0;
            div_high_q <= '0;
        end else if (timeout) begin
            div_busy_q <= 1'b0;
            div_done_q <= 1'b0;
        end else if (capture && !div_busy_q && !div_done_q) begin
            div_busy_q <= 1'b1;
            div_cnt_q  <= Steps;
            div_num_q  <= NUM_W'(high_lat_q) * Scale;
            div_quo_q  <= '0;
            div_rem_q  <= '0;
            div_den_q  <= period_cnt_q;
            div_high_q <= high_lat_q;
        end else if (div_busy_q) begin
            div_rem_q <= div_rem_next;
            div_quo_q <= {div_quo_q[NUM_W-2:0], div_qbit};
            div_num_q <= div_num_q << 1;
            div_cnt_q <= div_cnt_q - STEP_W'(1);
            if (div_cnt_q == STEP_W'(1)) begin
                div_busy_q <= 1'b0;
                div_done_q <= 1'b1;
            end
        end else if (div_done_q) begin
            div_done_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_24M or posedge rst) begin
        if (rst) begin
            perctg_out <= '0;
            period_out <= '0;
            high_out   <= '0;
            valid      <= 1'b0;
            stuck      <= 1'b0;
        end else if (timeout) begin
            perctg_out <= sync_q[1] ? PerMille : 11'd0;
            period_out <= '0;
            high_out   <= '0;
            valid      <= 1'b1;
            stuck      <= 1'b1;
        end else if (div_done_q) begin
            perctg_out <= (div_quo_q > NUM_W'(1000)) ? PerMille : div_quo_q[10:0];
            period_out <= div_den_q;
            high_out   <= div_high_q;
            valid      <= 1'b1;
            stuck      <= 1'b0;
        end else begin
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Randomised bench for pwm_capture: an event-level model predicts every valid pulse
// (time and payload) from the applied edge times.
module tb_pwm_capture;

    localparam int CNT_W     = 26;
    localparam int TIMEOUT   = 19200;
    localparam int DIV_LAT   = 40;           // input change -> valid: 3 sync/edge + 37 divide
    localparam int STUCK_LAT = TIMEOUT + 3;
    localparam int BUSY_WIN  = 38;           // min spacing between accepted capture rises
    localparam int TOL       = 1;

    logic             clk_24M = 1'b0;
    logic             rst     = 1'b1;
    logic             pwm_in  = 1'b0;
    logic [10:0]      perctg_out;
    logic [CNT_W-1:0] period_out, high_out;
    logic             valid, stuck;

    pwm_capture dut (
        .clk_24M    (clk_24M),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .perctg_out (perctg_out),
        .period_out (period_out),
        .high_out   (high_out),
        .valid      (valid),
        .stuck      (stuck)
    );

    always #5 clk_24M = ~clk_24M;

    typedef struct {
        int t;
        int perctg;
        int period;
        int high;
        bit stk;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_errors = 0;
    bit  run_armed, have_fall;
    int  last_rise_c, fall_c, last_acc;
    int  last_perctg, last_period, last_high;
    bit  last_stuck;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        exp_q.delete();
        run_armed   = 1'b0;
        have_fall   = 1'b0;
        last_rise_c = -1;
        fall_c      = -1;
        last_acc    = -1000000;
        last_perctg = 0;
        last_period = 0;
        last_high   = 0;
        last_stuck  = 1'b0;
    endfunction

    // Input edge at cycle c: a rise after a complete armed pulse yields a measurement,
    // kept only when the previous accepted measurement has finished dividing.
    function automatic void model_edge(input bit v, input int c);
        int p, h, d;
        if (v) begin
            if (run_armed && have_fall) begin
                p = c - last_rise_c;
                h = fall_c - last_rise_c;
                if (c - last_acc >= BUSY_WIN) begin
                    d = (h * 1000) / p;
                    if (d > 1000) d = 1000;
                    exp_q.push_back('{t: c + DIV_LAT, perctg: d, period: p, high: h, stk: 1'b0});
                    last_acc = c;
                end
            end
            run_armed   = 1'b1;
            have_fall   = 1'b0;
            last_rise_c = c;
        end else begin
            fall_c    = c;
            have_fall = 1'b1;
        end
    endfunction

    // Level v held from cycle c for n cycles: predict a timeout inside this segment
    function automatic void model_segment(input bit v, input int c, input int n);
        if (run_armed && (c + n - last_rise_c > TIMEOUT)) begin
            exp_q.push_back('{t: last_rise_c + STUCK_LAT, perctg: v ? 1000 : 0,
                              period: 0, high: 0, stk: 1'b1});
            run_armed = 1'b0;
        end
    endfunction

    task automatic set_level(input bit v, input int n);
        @(negedge clk_24M);
        if (v != pwm_in) model_edge(v, cyc);
        model_segment(v, cyc, n);
        pwm_in = v;
        repeat (n - 1) @(negedge clk_24M);
    endtask

    task automatic pulse(input int p, input int h);
        set_level(1'b1, h);
        set_level(1'b0, p - h);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_24M);
    endtask

    task automatic check_hold(input string tag);
        check_eq({tag, "_perctg"}, perctg_out, last_perctg);
        check_eq({tag, "_period"}, period_out, last_period);
        check_eq({tag, "_high"},   high_out,   last_high);
        check_eq({tag, "_stuck"},  stuck,      last_stuck);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk_24M);
        rst    = 1'b1;
        pwm_in = 1'b0;
        model_reset();
        #1;
        check_eq("rst_perctg", perctg_out, 0);
        check_eq("rst_period", period_out, 0);
        check_eq("rst_high",   high_out,   0);
        check_eq("rst_valid",  valid,      0);
        check_eq("rst_stuck",  stuck,      0);
        repeat (n) @(negedge clk_24M);
        rst = 1'b0;
    endtask

    // Monitor: every valid must match the oldest predicted event, on time
    initial begin
        ev_t e;
        int  d;
        forever begin
            @(posedge clk_24M);
            cyc++;
            #1;
            if (!rst) begin
                if (valid) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_valid", valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        d = cyc - e.t;
                        check_eq("valid_time_offset", (d >= -TOL && d <= TOL) ? 0 : d, 0);
                        check_eq("valid_perctg", perctg_out, e.perctg);
                        check_eq("valid_period", period_out, e.period);
                        check_eq("valid_high",   high_out,   e.high);
                        check_eq("valid_stuck",  stuck,      e.stk);
                        last_perctg = e.perctg;
                        last_period = e.period;
                        last_high   = e.high;
                        last_stuck  = e.stk;
                    end
                end else if (exp_q.size() > 0 && cyc > exp_q[0].t + TOL) begin
                    check_eq("missing_valid", valid, 1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        repeat (95000) @(posedge clk_24M);
        $display("FAIL watchdog: got cycle %0d expected completion earlier", cyc);
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p, h;
        model_reset();
        do_reset(4);

        // 5 kHz, 25 % duty
        repeat (3) pulse(4800, 1200);
        check_hold("p5k");
        check_eq("p5k_duty", perctg_out, 250);

        // duty step 30 % -> 75 %
        pulse(4800, 1440);
        repeat (2) pulse(4800, 3600);
        check_hold("step");
        check_eq("step_duty", perctg_out, 750);
        check_eq("step_high", high_out, 3600);

        // truncation; most captures dropped while the divider is busy
        repeat (40) pulse(3, 1);
        idle(45);
        check_hold("p3");
        check_eq("p3_duty", perctg_out, 333);

        repeat (20) pulse(20, 10);
        idle(45);
        check_hold("p20");
        check_eq("p20_duty", perctg_out, 500);

        for (int i = 0; i < 40; i++) begin
            p = $urandom_range(300, 3);
            h = $urandom_range(p - 1, 1);
            pulse(p, h);
        end
        idle(45);
        check_hold("rand");

        // dead line held high, then held low
        repeat (3) pulse(1200, 600);
        set_level(1'b1, 19300);
        check_hold("stuck_hi");
        check_eq("stuck_hi_flag", stuck, 1);
        check_eq("stuck_hi_duty", perctg_out, 1000);
        check_eq("stuck_hi_period", period_out, 0);
        set_level(1'b0, 100);
        repeat (3) pulse(1200, 600);
        check_hold("recover");
        check_eq("recover_stuck", stuck, 0);
        set_level(1'b0, 19300);
        check_hold("stuck_lo");
        check_eq("stuck_lo_duty", perctg_out, 0);

        // reset 5 cycles after a capturing rise aborts the division
        repeat (2) pulse(200, 50);
        set_level(1'b1, 5);
        do_reset(4);
        repeat (3) pulse(200, 50);
        idle(45);
        check_hold("post_rst");
        check_eq("post_rst_duty", perctg_out, 250);

        idle(60);
        check_eq("events_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
